// File: rtl/comparador_sweep_checker.sv
// Self-checking sweep engine for a 2-bit magnitude comparator: drives every
// {D,C,B,A} code in order, samples Y/Z after a settle window, and records errors.
module comparador_sweep_checker #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       D,
    output logic       C,
    output logic       B,
    output logic       A,
    input  logic       Y,
    input  logic       Z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       first_err_valid,
    output logic [3:0] first_err_code
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_VAL = 4'(SETTLE);

    state_t     state;
    state_t     next_state;
    logic [3:0] code;
    logic [3:0] settle_cnt;
    logic       accept;
    logic       sample;
    logic       last_code;
    logic       exp_y;
    logic       exp_z;
    logic       mismatch;

    assign accept    = start && (state == IDLE || state == FIN);
    assign sample    = (state == RUN) && (settle_cnt == 4'd0);
    assign last_code = (code == 4'd15);
    assign exp_y     = code[3:2] > code[1:0];
    assign exp_z     = code[3:2] == code[1:0];
    assign mismatch  = (Y != exp_y) || (Z != exp_z);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (sample && last_code) next_state = FIN;
            FIN:     if (start) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state == RUN);
        done         = (state == FIN);
        pass         = (state == FIN) && (err_count == 5'd0);
        {D, C, B, A} = code;
    end

    // The code stays at 15 after the final sample, so the stimulus holds 4'b1111 in FIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            code            <= 4'd0;
            settle_cnt      <= 4'd0;
            err_count       <= 5'd0;
            first_err_valid <= 1'b0;
            first_err_code  <= 4'd0;
        end else if (accept) begin
            code            <= 4'd0;
            settle_cnt      <= SETTLE_VAL;
            err_count       <= 5'd0;
            first_err_valid <= 1'b0;
            first_err_code  <= 4'd0;
        end else if (sample) begin
            if (mismatch) begin
                if (err_count != 5'd16) begin
                    err_count <= err_count + 5'd1;
                end
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_code  <= code;
                end
            end
            if (!last_code) begin
                code       <= code + 4'd1;
                settle_cnt <= SETTLE_VAL;
            end
        end else if (state == RUN) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_comparador_sweep_checker.sv
// Randomized bench for comparador_sweep_checker: a table-driven comparator model
// (with injectable faults) answers the sweep, and a reference model predicts results.
module tb_comparador_sweep_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic        d0, c0, b0, a0, d1, c1, b1, a1;
    logic        y0, z0, y1, z1;
    logic        busy0, done0, pass0, fev0, busy1, done1, pass1, fev1;
    logic [4:0]  err0, err1;
    logic [3:0]  fec0, fec1;
    logic [3:0]  code0, code1;
    logic [15:0] y_resp, z_resp;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign code0 = {d0, c0, b0, a0};
    assign code1 = {d1, c1, b1, a1};
    assign y0 = y_resp[code0];
    assign z0 = z_resp[code0];
    assign y1 = y_resp[code1];
    assign z1 = z_resp[code1];

    comparador_sweep_checker #(.SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start0),
        .D(d0), .C(c0), .B(b0), .A(a0), .Y(y0), .Z(z0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_err_valid(fev0), .first_err_code(fec0)
    );

    comparador_sweep_checker #(.SETTLE(0)) dut_fast (
        .clk(clk), .rst(rst), .start(start1),
        .D(d1), .C(c1), .B(b1), .A(a1), .Y(y1), .Z(z1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_valid(fev1), .first_err_code(fec1)
    );

    function automatic int getCode(int sel);  return sel ? int'(code1) : int'(code0); endfunction
    function automatic int getBusy(int sel);  return sel ? int'(busy1) : int'(busy0); endfunction
    function automatic int getDone(int sel);  return sel ? int'(done1) : int'(done0); endfunction
    function automatic int getPass(int sel);  return sel ? int'(pass1) : int'(pass0); endfunction
    function automatic int getErr(int sel);   return sel ? int'(err1)  : int'(err0);  endfunction
    function automatic int getFev(int sel);   return sel ? int'(fev1)  : int'(fev0);  endfunction
    function automatic int getFec(int sel);   return sel ? int'(fec1)  : int'(fec0);  endfunction

    task automatic setStart(input int sel, input bit v);
        if (sel != 0) start1 = v;
        else start0 = v;
    endtask

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // An ideal comparator: X={D,C} against W={B,A}, unsigned.
    task automatic setIdeal();
        for (int c = 0; c < 16; c++) begin
            y_resp[c] = (c / 4) > (c % 4);
            z_resp[c] = (c / 4) == (c % 4);
        end
    endtask

    // Reference: walk all codes, count those whose response table disagrees with the ideal compare.
    task automatic refModel(output int errs, output int first);
        errs  = 0;
        first = -1;
        for (int c = 0; c < 16; c++) begin
            if ((y_resp[c] != ((c / 4) > (c % 4))) || (z_resp[c] != ((c / 4) == (c % 4)))) begin
                errs++;
                if (first < 0) first = c;
            end
        end
    endtask

    task automatic checkIdleZero(input int sel, input string tag);
        checkOutput({tag, "_code"}, getCode(sel), 0);
        checkOutput({tag, "_busy"}, getBusy(sel), 0);
        checkOutput({tag, "_done"}, getDone(sel), 0);
        checkOutput({tag, "_pass"}, getPass(sel), 0);
        checkOutput({tag, "_err"},  getErr(sel),  0);
        checkOutput({tag, "_fev"},  getFev(sel),  0);
        checkOutput({tag, "_fec"},  getFec(sel),  0);
    endtask

    // Pulse start, follow the sweep cycle by cycle, then check the final verdict.
    task automatic applyStimulus(input int sel, input int rst_at, input bit pulse_mid);
        int hold;
        int k;
        int errs;
        int first;
        hold = (sel != 0) ? 1 : 3;
        k = 0;
        refModel(errs, first);
        @(negedge clk);
        setStart(sel, 1'b1);
        @(negedge clk);
        setStart(sel, 1'b0);
        while (getDone(sel) == 0 && k < 200) begin
            checkOutput("busy", getBusy(sel), 1);
            checkOutput("code", getCode(sel), k / hold);
            if (k == 0) begin
                checkOutput("clr_err", getErr(sel), 0);
                checkOutput("clr_fev", getFev(sel), 0);
            end
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkIdleZero(sel, "abort");
                return;
            end
            if (pulse_mid) setStart(sel, k == 5);
            @(negedge clk);
            k++;
        end
        setStart(sel, 1'b0);
        checkOutput("done_latency", k, 16 * hold);
        checkOutput("done_code", getCode(sel), 15);
        checkOutput("done_busy", getBusy(sel), 0);
        checkOutput("err_count", getErr(sel), errs);
        checkOutput("pass", getPass(sel), (errs == 0) ? 1 : 0);
        checkOutput("first_err_valid", getFev(sel), (errs > 0) ? 1 : 0);
        checkOutput("first_err_code", getFec(sel), (first < 0) ? 0 : first);
        @(negedge clk);
        checkOutput("done_hold", getDone(sel), 1);
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        setIdeal();
        repeat (3) @(negedge clk);
        checkIdleZero(0, "reset");
        checkIdleZero(1, "reset_fast");
        rst = 1'b0;

        $display("[TB] ideal sweep, SETTLE=2, with extra start pulse mid-sweep");
        applyStimulus(0, -1, 1'b1);

        $display("[TB] Y stuck at 0");
        y_resp = 16'h0000;
        applyStimulus(0, -1, 1'b0);

        $display("[TB] Z inverted");
        setIdeal();
        z_resp = ~z_resp;
        applyStimulus(0, -1, 1'b0);

        $display("[TB] rerun from done with ideal comparator");
        setIdeal();
        applyStimulus(0, -1, 1'b0);

        $display("[TB] reset 20 cycles into a sweep, then a fresh sweep");
        applyStimulus(0, 20, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("idle_busy", getBusy(0), 0);
        checkOutput("idle_done", getDone(0), 0);
        applyStimulus(0, -1, 1'b0);

        $display("[TB] reset and start together");
        rst = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start0 = 1'b0;
        checkIdleZero(0, "rst_start");

        $display("[TB] ideal sweep, SETTLE=0");
        applyStimulus(1, -1, 1'b0);

        $display("[TB] randomized fault patterns");
        for (int i = 0; i < 8; i++) begin
            logic [15:0] ym;
            logic [15:0] zm;
            setIdeal();
            ym = 16'($urandom & $urandom);
            zm = 16'($urandom & $urandom & $urandom);
            if (i == 2) begin
                ym = 16'h0000;
                zm = 16'h0000;
            end
            y_resp = y_resp ^ ym;
            z_resp = z_resp ^ zm;
            applyStimulus(i % 2, -1, ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
